// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word-addressed RAM with a fixed multi-cycle
// access latency, a pipeline stall request, and address-error reporting. Optional trace: DMEM_TRACE_EN.
module dmem_responder #(
   parameter int DEPTH_WORDS = 32,
   parameter int LATENCY     = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] Addr_i,
   input  logic [31:0] WriteData_i,
   output logic [31:0] ReadData_o,
   output logic        Ready_o,
   output logic        Stall_o,
   output logic        AddrErr_o
);

   localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               wr_q, wr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic [31:0]        mem_q [DEPTH_WORDS];

   logic               req;
   logic               legal;
   logic               stall;
   logic               complete;
   logic               comp_wr;
   logic [IDX_W-1:0]   comp_idx;
   logic [31:0]        comp_wdata;
   logic               mem_we;

   assign req   = MemRead_i | MemWrite_i;
   assign legal = (Addr_i[1:0] == 2'b00) && (Addr_i < ADDR_LIMIT);

   // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      stall      = 1'b0;
      complete   = 1'b0;
      comp_wr    = wr_q;
      comp_idx   = idx_q;
      comp_wdata = wdata_q;

      case (state_q)
         IDLE: begin
            if (req && legal) begin
               stall   = 1'b1;
               idx_d   = Addr_i[IDX_W+1:2];
               wr_d    = MemWrite_i;
               wdata_d = WriteData_i;
               if (LATENCY == 1) begin
                  // Single-cycle access completes at this edge, straight from the inputs.
                  state_d    = DONE;
                  complete   = 1'b1;
                  comp_wr    = MemWrite_i;
                  comp_idx   = Addr_i[IDX_W+1:2];
                  comp_wdata = WriteData_i;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end else if (req) begin
               state_d = DONE;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d  = DONE;
               complete = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete) begin
         ready_d = 1'b1;
         if (!comp_wr) begin
            rdata_d = mem_q[comp_idx];
         end
      end
   end

   // A reset arriving on the completing edge must not commit the store.
   assign mem_we  = complete && comp_wr && !rst_i;
   assign Stall_o = stall && !rst_i;

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the RAM array has no reset; clearing it would turn it into a huge flop bank.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[comp_idx] <= comp_wdata;
      end
   end

   assign ReadData_o = rdata_q;
   assign Ready_o    = ready_q;
   assign AddrErr_o  = err_q;

`ifdef DMEM_TRACE_EN
   logic [31:0] trace_addr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         trace_addr_q <= '0;
      end else if (state_q == IDLE && req) begin
         trace_addr_q <= Addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && state_q == DONE) begin
         if (err_q) begin
            $display("dmem ERR addr=%08h data=%08h", trace_addr_q, 32'h0);
         end else if (wr_q) begin
            $display("dmem W   addr=%08h data=%08h", trace_addr_q, wdata_q);
         end else begin
            $display("dmem R   addr=%08h data=%08h", trace_addr_q, rdata_q);
         end
      end
   end
`else
   // Trace disabled: the block produces no simulation output.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder: one instance at LATENCY=3
// and one at LATENCY=1, compared cycle by cycle against hand-computed vectors.
module tb_dmem_responder;

   typedef struct {
      bit          sel;      // 0: LATENCY=3 instance, 1: LATENCY=1 instance
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic        ready;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        rd0, wr0, rd1, wr1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [31:0] rdata0, rdata1;
   logic        ready0, stall0, err0, ready1, stall1, err1;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(32), .LATENCY(3)) dut (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(rd0), .MemWrite_i(wr0),
      .Addr_i(addr0), .WriteData_i(wdata0), .ReadData_o(rdata0),
      .Ready_o(ready0), .Stall_o(stall0), .AddrErr_o(err0)
   );

   dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut_l1 (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(rd1), .MemWrite_i(wr1),
      .Addr_i(addr1), .WriteData_i(wdata1), .ReadData_o(rdata1),
      .Ready_o(ready1), .Stall_o(stall1), .AddrErr_o(err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      if (v.sel) begin
         rd1 = v.rd; wr1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
      end else begin
         rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
      end
   endtask

   // One cycle: drive after the rising edge, sample at the falling edge.
   task automatic step(input vec_t v, input string name);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      if (v.sel) begin
         check({name, " stall"}, 32'(stall1), 32'(v.stall));
         check({name, " ready"}, 32'(ready1), 32'(v.ready));
         check({name, " err"},   32'(err1),   32'(v.err));
         check({name, " rdata"}, rdata1,      v.rdata);
      end else begin
         check({name, " stall"}, 32'(stall0), 32'(v.stall));
         check({name, " ready"}, 32'(ready0), 32'(v.ready));
         check({name, " err"},   32'(err0),   32'(v.err));
         check({name, " rdata"}, rdata0,      v.rdata);
      end
   endtask

   function automatic vec_t mk(bit sel, logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                               logic stall, logic ready, logic err, logic [31:0] rdata);
      vec_t v;
      v.sel = sel; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.stall = stall; v.ready = ready; v.err = err; v.rdata = rdata;
      return v;
   endfunction

   initial begin
      // Main table: LATENCY=3 instance, then LATENCY=1 instance.
      // Store 0x12345678 @0x8, load it back.
      repeat (3) vq.push_back(mk(0, 0, 1, 32'h8, 32'h12345678, 1, 0, 0, 32'h11112222));
      vq.push_back(mk(0, 0, 1, 32'h8, 32'h12345678, 0, 1, 0, 32'h11112222));
      repeat (3) vq.push_back(mk(0, 1, 0, 32'h8, 32'h0, 1, 0, 0, 32'h11112222));
      vq.push_back(mk(0, 1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h12345678));
      // Read+write together acts as a store; load confirms.
      repeat (3) vq.push_back(mk(0, 1, 1, 32'h4, 32'hAAAA5555, 1, 0, 0, 32'h12345678));
      vq.push_back(mk(0, 1, 1, 32'h4, 32'hAAAA5555, 0, 1, 0, 32'h12345678));
      repeat (3) vq.push_back(mk(0, 1, 0, 32'h4, 32'h0, 1, 0, 0, 32'h12345678));
      vq.push_back(mk(0, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'hAAAA5555));
      // Misaligned store: error pulse, ReadData cleared, array untouched.
      vq.push_back(mk(0, 0, 1, 32'h6, 32'hBAD0BAD0, 0, 0, 0, 32'hAAAA5555));
      vq.push_back(mk(0, 0, 0, 32'h0, 32'h0,        0, 1, 1, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0));
      repeat (3) vq.push_back(mk(0, 1, 0, 32'h4, 32'h0, 1, 0, 0, 32'h0));
      vq.push_back(mk(0, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'hAAAA5555));
      // Out-of-range load at 0x80.
      vq.push_back(mk(0, 1, 0, 32'h80, 32'h0, 0, 0, 0, 32'hAAAA5555));
      vq.push_back(mk(0, 0, 0, 32'h0,  32'h0, 0, 1, 1, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0));
      // Highest legal word 0x7C.
      repeat (3) vq.push_back(mk(0, 0, 1, 32'h7C, 32'hCAFEF00D, 1, 0, 0, 32'h0));
      vq.push_back(mk(0, 0, 1, 32'h7C, 32'hCAFEF00D, 0, 1, 0, 32'h0));
      repeat (3) vq.push_back(mk(0, 1, 0, 32'h7C, 32'h0, 1, 0, 0, 32'h0));
      vq.push_back(mk(0, 1, 0, 32'h7C, 32'h0, 0, 1, 0, 32'hCAFEF00D));
      // LATENCY=1: preload 0x0=1, 0x4=2, then back-to-back loads.
      vq.push_back(mk(1, 0, 1, 32'h0, 32'h1, 1, 0, 0, 32'h0));
      vq.push_back(mk(1, 0, 1, 32'h0, 32'h1, 0, 1, 0, 32'h0));
      vq.push_back(mk(1, 0, 1, 32'h4, 32'h2, 1, 0, 0, 32'h0));
      vq.push_back(mk(1, 0, 1, 32'h4, 32'h2, 0, 1, 0, 32'h0));
      vq.push_back(mk(1, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0));
      vq.push_back(mk(1, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h1));
      vq.push_back(mk(1, 1, 0, 32'h4, 32'h0, 1, 0, 0, 32'h1));
      vq.push_back(mk(1, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'h2));
      vq.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h2));

      // Reset state, including a request visible during reset.
      rst_i = 1'b1;
      drive(mk(0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst stall",   32'(stall0), 32'h0);
      check("rst ready",   32'(ready0), 32'h0);
      check("rst err",     32'(err0),   32'h0);
      check("rst rdata",   rdata0,      32'h0);
      check("rst l1 rdy",  32'(ready1), 32'h0);
      drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
      rst_i = 1'b0;

      // Reset in the middle of a store: the old value must survive.
      repeat (3) step(mk(0, 0, 1, 32'h10, 32'h11112222, 1, 0, 0, 32'h0), "pre st");
      step(mk(0, 0, 1, 32'h10, 32'h11112222, 0, 1, 0, 32'h0), "pre done");
      repeat (2) step(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0), "abort st");
      @(posedge clk);
      #1;
      drive(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0));
      #1;
      check("busy2 stall", 32'(stall0), 32'h1);
      rst_i = 1'b1;
      #1;
      check("rst mid stall", 32'(stall0), 32'h0);
      check("rst mid ready", 32'(ready0), 32'h0);
      @(negedge clk);
      drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
      rst_i = 1'b0;
      repeat (3) step(mk(0, 1, 0, 32'h10, 32'h0, 1, 0, 0, 32'h0), "post ld");
      step(mk(0, 1, 0, 32'h10, 32'h0, 0, 1, 0, 32'h11112222), "post ld done");

      // Table sweep.
      foreach (vq[i]) step(vq[i], $sformatf("v%0d", i));

      // Idle: nothing pulses, load data holds.
      for (int i = 0; i < 10; i++)
         step(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'hCAFEF00D), $sformatf("idle%0d", i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
